// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Latches digits on load; adds leading-zero blanking, decimal points and blink.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] RefreshMax = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BlinkMax   = BW'(BLINK_DIV - 1);

    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic [1:0]    idx_q, idx_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    an_n_q, an_n_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic          dp_n_q, dp_n_d;

    logic [3:0]    digit_v;
    logic [6:0]    seg_dec;
    logic [3:0]    lz;
    logic          blink_off;

    always_comb begin
        shadow_d    = load ? digits : shadow_q;
        shadow_dp_d = load ? dp_mask : shadow_dp_q;

        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == RefreshMax) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end

        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == BlinkMax) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // A digit is a leading zero when it and every higher digit are zero; ones never blanks.
    always_comb begin
        lz[3] = (shadow_q[15:12] == 4'd0);
        lz[2] = lz[3] && (shadow_q[11:8] == 4'd0);
        lz[1] = lz[2] && (shadow_q[7:4] == 4'd0);
        lz[0] = 1'b0;
    end

    always_comb begin
        digit_v = shadow_q[{idx_q, 2'b00} +: 4];
        case (digit_v)
            4'h0:    seg_dec = 7'b1000000;
            4'h1:    seg_dec = 7'b1111001;
            4'h2:    seg_dec = 7'b0100100;
            4'h3:    seg_dec = 7'b0110000;
            4'h4:    seg_dec = 7'b0011001;
            4'h5:    seg_dec = 7'b0010010;
            4'h6:    seg_dec = 7'b0000010;
            4'h7:    seg_dec = 7'b1111000;
            4'h8:    seg_dec = 7'b0000000;
            4'h9:    seg_dec = 7'b0010000;
            4'hA:    seg_dec = 7'b0001000;
            4'hB:    seg_dec = 7'b0000011;
            4'hC:    seg_dec = 7'b1000110;
            4'hD:    seg_dec = 7'b0100001;
            4'hE:    seg_dec = 7'b0000110;
            default: seg_dec = 7'b0001110;
        endcase
    end

    always_comb begin
        blink_off = blink_en && phase_q;
        an_n_d    = ~(4'b0001 << idx_q);
        seg_n_d   = (blink_off || (blank_lz && lz[idx_q])) ? 7'h7F : seg_dec;
        dp_n_d    = blink_off ? 1'b1 : ~shadow_dp_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            idx_q       <= '0;
            refresh_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            an_n_q      <= 4'b1111;
            seg_n_q     <= 7'h7F;
            dp_n_q      <= 1'b1;
        end else begin
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            idx_q       <= idx_d;
            refresh_q   <= refresh_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            an_n_q      <= an_n_d;
            seg_n_q     <= seg_n_d;
            dp_n_q      <= dp_n_d;
        end
    end

    assign an_n  = an_n_q;
    assign seg_n = seg_n_q;
    assign dp_n  = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver against a cycle-count based model.
module tb_seg7_scan_driver;

    localparam int RD = 4;
    localparam int BD = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    int n_checks = 0;
    int n_errors = 0;

    // Model: cycles since reset release plus the latched digits
    int          cnt = 0;
    logic [15:0] sh_m = '0;
    logic [3:0]  dp_m = '0;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;

    seg7_scan_driver #(
        .REFRESH_DIV(RD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .digits  (digits),
        .dp_mask (dp_mask),
        .blank_lz(blank_lz),
        .blink_en(blink_en),
        .an_n    (an_n),
        .seg_n   (seg_n),
        .dp_n    (dp_n)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Active-high lit segments, gfedcba
    function automatic logic [6:0] lit(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    task automatic step();
        int   idx;
        logic blink;
        logic blanked;
        @(posedge clk);
        if (!reset) begin
            cnt = 0; sh_m = '0; dp_m = '0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            idx     = (cnt / RD) % 4;
            blink   = blink_en && (((cnt / BD) % 2) == 1);
            blanked = blank_lz && (idx != 0) && ((sh_m >> (4 * idx)) == 16'd0);
            exp_an  = ~(4'b0001 << idx);
            exp_seg = (blink || blanked) ? 7'h7F : ~lit(sh_m[4*idx +: 4]);
            exp_dp  = blink ? 1'b1 : ~dp_m[idx];
            cnt++;
            if (load) begin
                sh_m = digits;
                dp_m = dp_mask;
            end
        end
        #1;
        check_eq("an_n", an_n, exp_an);
        check_eq("seg_n", seg_n, exp_seg);
        check_eq("dp_n", dp_n, exp_dp);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        load = 1'b1; digits = d; dp_mask = dp;
        step();
        load = 1'b0;
        step();
    endtask

    initial begin
        #1;
        // Reset and basic scan
        repeat (3) step();
        check_eq("rst_an", an_n, 4'hF);
        check_eq("rst_seg", seg_n, 7'h7F);
        reset = 1'b1;
        load = 1'b1; digits = 16'h0123;
        step();
        check_eq("first_an", an_n, 4'b1110);
        load = 1'b0;
        repeat (32) step();

        // Leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0007, 4'b0000);
        repeat (16) begin
            step();
            check_eq("lz7", seg_n, (an_n == 4'b1110) ? 7'b1111000 : 7'h7F);
        end
        do_load(16'h0000, 4'b0100);
        repeat (16) begin
            step();
            check_eq("dp_blank", dp_n, (an_n == 4'b1011) ? 1'b0 : 1'b1);
        end
        do_load(16'h0105, 4'b0000);
        repeat (16) step();

        // Load on the edge where idx wraps 3 -> 0
        blank_lz = 1'b0;
        do_load(16'h0009, 4'b0000);
        for (int i = 0; i < 16 && (cnt % 16) != 15; i++) step();
        check_eq("wrap_sync", cnt % 16, 15);
        load = 1'b1; digits = 16'h0004;
        step();
        load = 1'b0;
        step();
        check_eq("wrap_an", an_n, 4'b1110);
        check_eq("wrap_seg", seg_n, 7'b0011001);

        // Blink
        blink_en = 1'b1;
        do_load(16'h1234, 4'b1111);
        repeat (48) step();
        blink_en = 1'b0;

        // Randomized traffic with occasional resets
        repeat (400) begin
            reset    = ($urandom_range(39) != 0);
            load     = ($urandom_range(3) == 0);
            digits   = 16'($urandom) >> (4 * $urandom_range(3));
            dp_mask  = 4'($urandom);
            blank_lz = 1'($urandom);
            blink_en = ($urandom_range(3) == 0);
            step();
        end
        reset = 1'b1; load = 1'b0; blink_en = 1'b0; blank_lz = 1'b0;

        // Mid-scan reset at idx 2
        do_load(16'h5678, 4'b0000);
        for (int i = 0; i < 16 && ((cnt / RD) % 4) != 2; i++) step();
        check_eq("mid_idx", (cnt / RD) % 4, 2);
        reset = 1'b0;
        step();
        check_eq("mid_an", an_n, 4'hF);
        check_eq("mid_seg", seg_n, 7'h7F);
        reset = 1'b1;
        step();
        repeat (16) begin
            step();
            check_eq("post_rst_zero", seg_n, 7'b1000000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the binary-to-decimal converter.
- Latches four 4-bit digit codes (thousands, hundreds, tens, ones) on a load strobe.
- Drives them onto one time-multiplexed 4-digit common-anode 7-segment display: one shared active-low segment bus plus four active-low anode enables.
- Adds optional leading-zero blanking, per-digit decimal points and a whole-display blink.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays selected. Legal range 1..2^20.
- BLINK_DIV, 25000000: clock cycles per blink half-period. Legal range 1..2^26.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-low reset
- load  input  1  when high at a clk edge, capture digits/dp_mask
- digits  input  16  [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones
- dp_mask  input  4  bit k lights the decimal point of digit k (0 = ones)
- blank_lz  input  1  enable leading-zero blanking
- blink_en  input  1  enable whole-display blink
- an_n  output  4  anode enables, active-low, bit k = digit k
- seg_n  output  7  segments, active-low, bit 6 = g … bit 0 = a
- dp_n  output  1  decimal point, active-low

Behaviour:
- Fixed decisions: one clock, clk. Reset is synchronous and active-low on port reset: state clears at a clk edge with reset==0.
- Reset values:
  - shadow digit register = 0, shadow dp = 0
  - scan index idx = 0, refresh counter = 0, blink counter = 0, blink phase = 0
  - an_n = 4'b1111, seg_n = 7'h7F, dp_n = 1
- Load:
  - load==1 at an edge: shadow <= digits, shadow dp <= dp_mask.
  - Load does not disturb idx or any counter.
  - load held high re-captures every cycle.
  - load during reset is ignored; reset wins.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1.
  - At the edge where it equals REFRESH_DIV-1, it wraps to 0 and idx <= idx+1 mod 4 (3 wraps to 0).
  - REFRESH_DIV=1: idx advances every cycle.
- Output registers (all outputs registered):
  - One cycle latency from idx/shadow to an_n/seg_n/dp_n.
  - an_n = ~(1<<idx), i.e. exactly one anode low, except the first cycle after reset (still all high).
- Decode, per idx digit value v:
  - 0..9 use standard patterns: 0 → 7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000.
  - 10..15 use hex patterns: A → 7'b0001000, F → 7'b0001110.
  - No illegal codes exist.
- Leading-zero blanking (blank_lz==1):
  - Digit k ∈ {3,2,1} is blanked iff shadow digit k and all higher digits equal 0.
  - Digit 0 is never blanked, so the value zero shows as "0".
  - Blanked digit: seg_n = 7'h7F; anode still cycles normally.
  - dp_n still follows dp_mask, so a lit dp survives blanking.
  - Blanking uses shadow values only, never live digits.
- Decimal point: dp_n = ~shadow_dp[idx].
- Blink:
  - Blink counter runs continuously, 0..BLINK_DIV-1; blink phase toggles at wrap.
  - blink_en==1 and phase==1: seg_n = 7'h7F and dp_n = 1; an_n continues scanning.
  - blink_en==0: the counter still runs but has no effect.
- Simultaneous events:
  - Load on the same edge as an idx advance: the next output cycle shows the new digit at the new idx.
  - Mid-scan reset: outputs go to reset values on the next edge; the scan restarts at idx 0.

Test Plan:
- Reset/scan (REFRESH_DIV=4), reset low 3 cycles then high, load 16'h0123:
  - → an_n sequence 1110,1101,1011,0111 repeating, each held 4 cycles.
  - → first anode low 1 cycle after reset release; seg_n matches 3,2,1,0 patterns per position.
- Leading zeros, blank_lz=1:
  - load 16'h0007 → digits 3..1 seg_n=7F, digit 0 = 7'b1111000.
  - load 16'h0000 → only digit 0 shows 7'b1000000.
  - load 16'h0105 → digit 3 blank, digits 2..0 show 1,0,5.
- Decimal point: dp_mask=4'b0100 with blank_lz=1, digits 16'h0000 → dp_n=0 only while an_n=1011, despite that digit being blanked.
- Load timing: load 16'h0009 then 16'h0004 on the edge where idx wraps 3→0 → next output cycle has an_n=1110 and seg_n=7'b0011001 (4).
- Blink: BLINK_DIV=8, blink_en=1 → seg_n=7F and dp_n=1 for 8 cycles, normal for 8 cycles, alternating; an_n never stops scanning.
- Mid-operation reset: assert reset for 1 cycle at idx=2 → next edge an_n=1111, seg_n=7F; shadow cleared, so the display shows 0 after release.
